// File: rtl/add_pkg.sv
// Definitions shared by the add block and its stimulus driver.
package add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } add_drv_state_t;

  localparam int ADD_MAGIC     = 42;
  localparam int ADD_N_DEFAULT = 5;

endpackage

// File: rtl/add_scoreboard.sv
// Expected-result pipe aligned with add's register, plus mismatch bookkeeping.
module add_scoreboard #(
  parameter int N = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic signed [31:0] i_value,
  input  logic [15:0]        i_idx,
  input  logic signed [31:0] i_result,
  output logic [15:0]        o_err_count,
  output logic [15:0]        o_first_err_idx
);

  logic               r_s1_valid, r_s2_valid;
  logic signed [31:0] r_s1_exp, r_s2_exp;
  logic [15:0]        r_s1_idx, r_s2_idx;
  logic [15:0]        r_err_count, r_first_err_idx;
  logic               w_mismatch;

  // Stage 1 loads alongside the driver's value register, stage 2 alongside add's result.
  assign w_mismatch = r_s2_valid && (i_result != r_s2_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid      <= 1'b0;
      r_s2_valid      <= 1'b0;
      r_s1_exp        <= '0;
      r_s2_exp        <= '0;
      r_s1_idx        <= '0;
      r_s2_idx        <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= 16'hFFFF;
    end else begin
      r_s1_valid <= i_valid;
      r_s1_exp   <= i_value + 32'(N);
      r_s1_idx   <= i_idx;
      r_s2_valid <= r_s1_valid;
      r_s2_exp   <= r_s1_exp;
      r_s2_idx   <= r_s1_idx;
      if (i_clr) begin
        r_err_count     <= '0;
        r_first_err_idx <= 16'hFFFF;
      end else if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        if (r_first_err_idx == 16'hFFFF) r_first_err_idx <= r_s2_idx;
      end
    end
  end

  assign o_err_count     = r_err_count;
  assign o_first_err_idx = r_first_err_idx;

endmodule

// File: rtl/add_driver.sv
// Drives an arithmetic sequence into add and checks each result against value + N.
module add_driver
  import add_pkg::*;
#(
  parameter int                 N      = ADD_N_DEFAULT,
  parameter int                 COUNT  = 16,
  parameter logic signed [31:0] START  = 0,
  parameter logic signed [31:0] STEP   = 1,
  parameter logic signed [31:0] MAGIC  = ADD_MAGIC,
  parameter bit                 FINISH = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic signed [31:0] value,
  input  logic signed [31:0] result,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [15:0]        first_err_idx
);

  add_drv_state_t     r_state;
  logic signed [31:0] r_value, r_last;
  logic [15:0]        r_idx;
  logic               r_busy, r_done;

  logic signed [31:0] w_v0, w_cand, w_next, w_sb_value;
  logic [15:0]        w_sb_idx;
  logic               w_start_ok, w_last_issue, w_sb_valid;

  // MAGIC is stepped over so add never sees its terminate value as stimulus.
  assign w_v0   = (START == MAGIC) ? START + STEP : START;
  assign w_cand = r_last + STEP;
  assign w_next = (w_cand == MAGIC) ? w_cand + STEP : w_cand;

  assign w_start_ok   = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last_issue = (r_state == ST_RUN) && (r_idx == 16'(COUNT - 1));

  // The scoreboard sees what value is about to become, so its stages track the edge timing.
  assign w_sb_valid = w_start_ok || (r_state == ST_RUN && !w_last_issue);
  assign w_sb_value = w_start_ok ? w_v0 : w_next;
  assign w_sb_idx   = w_start_ok ? 16'd0 : r_idx + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_value <= '0;
      r_last  <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_value <= '0;
          if (start) begin
            r_state <= ST_RUN;
            r_value <= w_v0;
            r_last  <= w_v0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_last_issue) begin
            r_state <= ST_DRAIN;
            r_value <= '0;
          end else begin
            r_value <= w_next;
            r_last  <= w_next;
            r_idx   <= r_idx + 16'd1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_value <= FINISH ? MAGIC : 32'sd0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  add_scoreboard #(.N(N)) u_sb (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (w_start_ok),
    .i_valid        (w_sb_valid),
    .i_value        (w_sb_value),
    .i_idx          (w_sb_idx),
    .i_result       (result),
    .o_err_count    (err_count),
    .o_first_err_idx(first_err_idx)
  );

  assign value = r_value;
  assign busy  = r_busy;
  assign done  = r_done;
  assign pass  = r_done && (err_count == 16'd0);

endmodule

// File: tb/tb_add_driver.sv
// Directed bench: several driver configurations, each paired with a behavioural add.
module tb_add_driver;

  logic clk = 1'b0;
  logic rst, start, inj;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Per-instance signals: b=basic, m=magic skip, w=wrap, x=wrap at 7FFFFFFF, f=finish
  logic signed [31:0] val_b, val_m, val_w, val_x, val_f;
  logic signed [31:0] res_b, res_m, res_w, res_x, res_f;
  logic busy_b, busy_m, busy_w, busy_x, busy_f;
  logic done_b, done_m, done_w, done_x, done_f;
  logic pass_b, pass_m, pass_w, pass_x, pass_f;
  logic [15:0] err_b, err_m, err_w, err_x, err_f;
  logic [15:0] fei_b, fei_m, fei_w, fei_x, fei_f;

  always @(posedge clk) begin
    if (rst) begin
      res_b <= 0; res_m <= 0; res_w <= 0; res_x <= 0; res_f <= 0;
    end else begin
      res_b <= val_b + 32'sd5 + ((inj && val_b == 32'sd2) ? 32'sd1 : 32'sd0);
      res_m <= val_m + 32'sd5;
      res_w <= val_w + 32'sd5;
      res_x <= val_x + 32'sd5;
      res_f <= val_f + 32'sd5;
    end
  end

  add_driver #(.COUNT(4), .START(32'sd0)) u_b (
    .clk(clk), .rst(rst), .start(start), .value(val_b), .result(res_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(fei_b));
  add_driver #(.COUNT(4), .START(32'sd40)) u_m (
    .clk(clk), .rst(rst), .start(start), .value(val_m), .result(res_m), .busy(busy_m),
    .done(done_m), .pass(pass_m), .err_count(err_m), .first_err_idx(fei_m));
  add_driver #(.COUNT(4), .START(32'hFFFFFFFD)) u_w (
    .clk(clk), .rst(rst), .start(start), .value(val_w), .result(res_w), .busy(busy_w),
    .done(done_w), .pass(pass_w), .err_count(err_w), .first_err_idx(fei_w));
  add_driver #(.COUNT(4), .START(32'h7FFFFFFF)) u_x (
    .clk(clk), .rst(rst), .start(start), .value(val_x), .result(res_x), .busy(busy_x),
    .done(done_x), .pass(pass_x), .err_count(err_x), .first_err_idx(fei_x));
  add_driver #(.COUNT(2), .FINISH(1'b1)) u_f (
    .clk(clk), .rst(rst), .start(start), .value(val_f), .result(res_f), .busy(busy_f),
    .done(done_f), .pass(pass_f), .err_count(err_f), .first_err_idx(fei_f));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inj = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_value", val_b, 32'd0);
    chk("rst_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_done", {31'd0, done_b}, 32'd0);
    chk("rst_pass", {31'd0, pass_b}, 32'd0);
    chk("rst_err", {16'd0, err_b}, 32'd0);
    chk("rst_fei", {16'd0, fei_b}, 32'h0000FFFF);
    tick();

    // Run 1: all configurations together
    start = 1'b1; tick(); start = 1'b0;          // after E0
    chk("r1_e0_val_b", val_b, 32'd0);
    chk("r1_e0_busy_b", {31'd0, busy_b}, 32'd1);
    chk("r1_e0_val_m", val_m, 32'd40);
    chk("r1_e0_val_w", val_w, 32'hFFFFFFFD);
    tick();                                       // E0+1
    chk("r1_e1_val_b", val_b, 32'd1);
    chk("r1_e1_res_b", res_b, 32'd5);
    chk("r1_e1_val_m", val_m, 32'd41);
    chk("r1_e1_res_w", res_w, 32'd2);
    chk("r1_e1_res_x", res_x, 32'h80000004);
    tick();                                       // E0+2
    chk("r1_e2_val_b", val_b, 32'd2);
    chk("r1_e2_val_m_skip", val_m, 32'd43);
    chk("r1_e2_val_f", val_f, 32'd0);
    tick();                                       // E0+3
    chk("r1_e3_val_b", val_b, 32'd3);
    chk("r1_e3_val_m", val_m, 32'd44);
    chk("r1_e3_res_m", res_m, 32'd48);
    chk("r1_e3_res_w", res_w, 32'd4);
    chk("r1_e3_val_f_magic", val_f, 32'd42);
    chk("r1_e3_done_f", {31'd0, done_f}, 32'd1);
    chk("r1_e3_pass_f", {31'd0, pass_f}, 32'd1);
    tick();                                       // E0+4
    chk("r1_e4_val_b", val_b, 32'd0);
    chk("r1_e4_res_b", res_b, 32'd8);
    chk("r1_e4_busy_b", {31'd0, busy_b}, 32'd1);
    chk("r1_e4_done_b", {31'd0, done_b}, 32'd0);
    chk("r1_e4_val_f", val_f, 32'd0);
    tick();                                       // E0+5
    chk("r1_busy_b", {31'd0, busy_b}, 32'd0);
    chk("r1_done_b", {31'd0, done_b}, 32'd1);
    chk("r1_pass_b", {31'd0, pass_b}, 32'd1);
    chk("r1_err_b", {16'd0, err_b}, 32'd0);
    chk("r1_fei_b", {16'd0, fei_b}, 32'h0000FFFF);
    chk("r1_pass_m", {31'd0, pass_m}, 32'd1);
    chk("r1_pass_w", {31'd0, pass_w}, 32'd1);
    chk("r1_pass_x", {31'd0, pass_x}, 32'd1);
    chk("r1_err_x", {16'd0, err_x}, 32'd0);
    tick();

    // Run 2: corrupt index 2 of the basic instance
    inj = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk("r2_done_clr", {31'd0, done_b}, 32'd0);
    repeat (5) tick();
    inj = 1'b0;
    chk("r2_done_b", {31'd0, done_b}, 32'd1);
    chk("r2_err_b", {16'd0, err_b}, 32'd1);
    chk("r2_fei_b", {16'd0, fei_b}, 32'd2);
    chk("r2_pass_b", {31'd0, pass_b}, 32'd0);
    chk("r2_pass_m", {31'd0, pass_m}, 32'd1);
    tick();

    // Run 3: reset at E0+2, then a clean rerun
    start = 1'b1; tick(); start = 1'b0;           // E0
    chk("r3_err_cleared", {16'd0, err_b}, 32'd0);
    tick();                                       // E0+1
    rst = 1'b1; tick(); rst = 1'b0;               // E0+2 samples rst
    chk("r3_rst_value", val_b, 32'd0);
    chk("r3_rst_busy", {31'd0, busy_b}, 32'd0);
    chk("r3_rst_done", {31'd0, done_b}, 32'd0);
    chk("r3_rst_fei", {16'd0, fei_b}, 32'h0000FFFF);
    repeat (4) tick();
    chk("r3_no_done", {31'd0, done_b}, 32'd0);
    chk("r3_idle_value", val_b, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("r3_restart_val", val_b, 32'd0);
    repeat (5) tick();
    chk("r3_done_b", {31'd0, done_b}, 32'd1);
    chk("r3_pass_b", {31'd0, pass_b}, 32'd1);
    chk("r3_err_b", {16'd0, err_b}, 32'd0);
    chk("r3_pass_w", {31'd0, pass_w}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
